line_fifo_sync: RTL and testbench
=================================

Name: line_fifo_sync

Overview:
- Single-clock first-word-fall-through (FWFT) FIFO buffering pixel/sample words between producer and consumer stages of the video pipeline.
- The head word is always presented on read_data while the FIFO is non-empty; a read pulse pops it.
- Provides full/empty flags and an occupancy count.

Parameters:
DATA_WIDTH  12  width of each stored word in bits
FIFO_DEPTH_WIDTH  10  pointer/count width; usable capacity = 2**FIFO_DEPTH_WIDTH - 1 entries (1023 at default)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
write  input  1  push request
read  input  1  pop request
write_data  input  DATA_WIDTH  word to push
read_data  output  DATA_WIDTH  current head word (FWFT)
wfull  output  1  FIFO holds 2**FIFO_DEPTH_WIDTH-1 words
rempty  output  1  FIFO holds 0 words
data_count_w  output  FIFO_DEPTH_WIDTH  occupancy, producer-side view
data_count_r  output  FIFO_DEPTH_WIDTH  occupancy, consumer-side view (identical to data_count_w)

Behaviour:
- Storage:
  - 2**FIFO_DEPTH_WIDTH-entry array; write pointer and read pointer are FIFO_DEPTH_WIDTH bits and wrap naturally modulo 2**FIFO_DEPTH_WIDTH.
  - Occupancy register is FIFO_DEPTH_WIDTH bits; maximum value is 2**W-1, so it never overflows.
  - Array contents are not reset.
- Reset, synchronous: rst=1 at a rising edge sets the following, and the same holds every cycle rst stays high:
  - pointers = 0, count = 0
  - rempty = 1, wfull = 0, data_count_w = data_count_r = 0, read_data = 0
  - read and write are ignored while rst=1.
- Write accept = write & ~wfull. On accept: array[wptr] <= write_data, wptr increments by 1.
- Write while wfull is dropped silently; there is no state change and no error flag.
- Read accept = read & ~rempty. On accept: rptr increments by 1.
- Read while rempty is ignored.
- Accept decisions use flag values from before the edge:
  - A simultaneous write and read on an empty FIFO accepts only the write.
  - On a full FIFO, only the read is accepted.
- Count update: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
- Flags are registered and derived from the next count:
  - rempty = (next count == 0)
  - wfull = (next count == 2**W-1)
- FWFT output:
  - read_data = array[rptr] combinationally whenever rempty=0; 0 when rempty=1.
  - A word written at edge N is visible on read_data, with rempty=0, immediately after edge N when the FIFO was empty.
  - After a read accepted at edge N, read_data shows the next word right after edge N.
- Latency: write-to-read-visibility is 1 edge; flags and counts update on the same edge as the accept.
- Ordering: strict FIFO order and no data corruption across pointer wrap.
- data_count_w and data_count_r are always equal.

Test Plan:
- Reset: hold rst=1 for 10 cycles, then release -> rempty=1, wfull=0, both counts 0, read_data=0.
- FWFT single word: write 12'hA5C at edge N -> after N: rempty=0, count=1, read_data=12'hA5C. Read at N+1 -> rempty=1, count=0, read_data=0.
- Interleaved stream:
  - Write 30 random words, write asserted every other cycle, while read runs every other cycle whenever rempty=0.
  - Repeat the burst twice.
  - Required: every popped read_data equals the reference-queue head, with zero mismatches.
- Fill/overflow:
  - Write 1023 words 0..1022 -> wfull=1, count=1023.
  - A further write of 12'hFFF is dropped.
  - Draining yields 0..1022 in order, then rempty=1.
- Simultaneous events:
  - At count=5, write+read on the same edge -> count stays 5, head advances.
  - Empty with write+read -> count becomes 1, written word appears.
  - Full with write+read -> count becomes 1022, wfull=0.
- Wrap and mid-operation reset:
  - Push and pop 3000 words through with occupancy at about 10, so data passes the pointer wrap intact.
  - Then, with count=7, assert rst for one cycle -> count=0, rempty=1, and old data is never output.

Source files
------------

// File: rtl/line_fifo_sync.sv
// rtl/line_fifo_sync.sv - single-clock first-word-fall-through line FIFO
//
// Buffers pixel/sample words between producer and consumer stages. The head
// word is presented on read_data whenever the FIFO is non-empty; a read pulse
// pops it. Usable capacity is 2**FIFO_DEPTH_WIDTH-1 words, so the occupancy
// count never needs more than FIFO_DEPTH_WIDTH bits.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   write         push request (ignored while wfull)
//   read          pop request (ignored while rempty)
//   write_data    word to push
//   read_data     current head word, 0 while empty
//   wfull         FIFO holds 2**FIFO_DEPTH_WIDTH-1 words
//   rempty        FIFO holds 0 words
//   data_count_w  occupancy, producer-side view
//   data_count_r  occupancy, consumer-side view (same value)
module line_fifo_sync #(
    parameter int DATA_WIDTH       = 12,
    parameter int FIFO_DEPTH_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic                        read,
    input  logic [DATA_WIDTH-1:0]       write_data,
    output logic [DATA_WIDTH-1:0]       read_data,
    output logic                        wfull,
    output logic                        rempty,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_w,
    output logic [FIFO_DEPTH_WIDTH-1:0] data_count_r
);

    localparam int                        DEPTH   = 1 << FIFO_DEPTH_WIDTH;
    localparam logic [FIFO_DEPTH_WIDTH-1:0] CNT_ONE = FIFO_DEPTH_WIDTH'(1);
    localparam logic [FIFO_DEPTH_WIDTH-1:0] CNT_MAX = '1;

    logic [DATA_WIDTH-1:0]       mem [DEPTH];
    logic [FIFO_DEPTH_WIDTH-1:0] wptr;
    logic [FIFO_DEPTH_WIDTH-1:0] rptr;
    logic [FIFO_DEPTH_WIDTH-1:0] count;
    logic [FIFO_DEPTH_WIDTH-1:0] next_count;
    logic                        wfull_q;
    logic                        rempty_q;
    logic                        wr_en;
    logic                        rd_en;

    // Accept decisions look only at the registered flags, so a write and a
    // read on an empty FIFO accept just the write, and on a full FIFO just
    // the read.
    assign wr_en = write & ~wfull_q & ~rst;
    assign rd_en = read & ~rempty_q & ~rst;

    always_comb begin
        next_count = count;
        case ({wr_en, rd_en})
            2'b10:   next_count = count + CNT_ONE;
            2'b01:   next_count = count - CNT_ONE;
            default: next_count = count;
        endcase
    end

    // Storage is not reset; stale entries are hidden by rempty gating below.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rempty_q <= 1'b1;
            wfull_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + CNT_ONE;
            end
            if (rd_en) begin
                rptr <= rptr + CNT_ONE;
            end
            count    <= next_count;
            rempty_q <= (next_count == '0);
            wfull_q  <= (next_count == CNT_MAX);
        end
    end

    // Head word falls through combinationally from the array; a word written
    // into an empty FIFO lands at mem[rptr] and shows up right after the edge.
    assign read_data    = rempty_q ? '0 : mem[rptr];
    assign wfull        = wfull_q;
    assign rempty       = rempty_q;
    assign data_count_w = count;
    assign data_count_r = count;

endmodule

// File: tb/tb_line_fifo_sync.sv
// tb/tb_line_fifo_sync.sv - directed self-checking bench for line_fifo_sync
module tb_line_fifo_sync;

    localparam int DW  = 12;
    localparam int AW  = 10;
    localparam int CAP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic [DW-1:0] read_data;
    logic          wfull;
    logic          rempty;
    logic [AW-1:0] data_count_w;
    logic [AW-1:0] data_count_r;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] ref_q[$];
    int            exp_cnt = 0;

    line_fifo_sync #(.DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .write        (write),
        .read         (read),
        .write_data   (write_data),
        .read_data    (read_data),
        .wfull        (wfull),
        .rempty       (rempty),
        .data_count_w (data_count_w),
        .data_count_r (data_count_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        logic [DW-1:0] head;
        head = (exp_cnt > 0) ? ref_q[0] : '0;
        check({tag, ".count_w"}, data_count_w, exp_cnt);
        check({tag, ".count_r"}, data_count_r, exp_cnt);
        check({tag, ".rempty"}, rempty, exp_cnt == 0);
        check({tag, ".wfull"}, wfull, exp_cnt == CAP);
        check({tag, ".head"}, read_data, head);
    endtask

    // One clock with the given requests; the reference queue decides what the
    // FIFO should accept using the occupancy from before the edge.
    task automatic cyc(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
        logic wa;
        logic ra;
        write      = w;
        read       = r;
        write_data = d;
        wa = w && (exp_cnt != CAP);
        ra = r && (exp_cnt != 0);
        if (ra) check({tag, ".pop"}, read_data, ref_q[0]);
        tick();
        if (ra) void'(ref_q.pop_front());
        if (wa) ref_q.push_back(d);
        exp_cnt = exp_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
        write = 1'b0;
        read  = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        rst   = 1'b1;
        write = w;
        read  = r;
        write_data = 12'hBAD;
        repeat (n) tick();
        ref_q.delete();
        exp_cnt = 0;
        check_state("reset_held");
        rst   = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        tick();
        check_state("reset_released");
    endtask

    initial begin
        // Reset with no activity
        do_reset(10, 1'b0, 1'b0);

        // FWFT single word
        cyc("fwft_wr", 1'b1, 1'b0, 12'hA5C);
        check("fwft_data", read_data, 12'hA5C);
        check("fwft_cnt", data_count_w, 1);
        cyc("fwft_rd", 1'b0, 1'b1, 12'h000);
        check("fwft_empty", rempty, 1'b1);
        check("fwft_zero", read_data, 12'h000);

        // Interleaved bursts: write on even cycles, read on odd cycles
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 60; i++) begin
                cyc("stream", (i % 2) == 0, (i % 2) == 1, DW'($urandom));
            end
        end
        while (exp_cnt > 0) cyc("stream_drain", 1'b0, 1'b1, '0);

        // Fill to capacity with 0..1022
        for (int i = 0; i < CAP; i++) cyc("fill", 1'b1, 1'b0, DW'(i));
        check("fill_wfull", wfull, 1'b1);
        check("fill_cnt", data_count_r, CAP);
        cyc("overflow", 1'b1, 1'b0, 12'hFFF);
        check("overflow_cnt", data_count_w, CAP);
        // Full with write+read: only the read (word 0) is accepted
        cyc("full_wr_rd", 1'b1, 1'b1, 12'h123);
        check("full_wr_rd_cnt", data_count_w, CAP - 1);
        check("full_wr_rd_head", read_data, 12'd1);
        for (int i = 1; i < CAP; i++) cyc("drain", 1'b0, 1'b1, '0);
        check("drain_empty", rempty, 1'b1);

        // Empty with write+read: only the write is accepted
        cyc("empty_wr_rd", 1'b1, 1'b1, 12'h3C3);
        check("empty_wr_rd_cnt", data_count_w, 1);
        check("empty_wr_rd_data", read_data, 12'h3C3);
        for (int i = 0; i < 4; i++) cyc("to5", 1'b1, 1'b0, DW'(12'h100 + i));
        cyc("cnt5_wr_rd", 1'b1, 1'b1, 12'h777);
        check("cnt5_wr_rd_cnt", data_count_r, 5);
        check("cnt5_wr_rd_head", read_data, 12'h100);
        while (exp_cnt > 0) cyc("drain5", 1'b0, 1'b1, '0);

        // Wrap: 3000 words through at occupancy ~10
        for (int i = 0; i < 10; i++) cyc("wrap_pre", 1'b1, 1'b0, DW'(12'h800 + i));
        for (int i = 0; i < 3000; i++) cyc("wrap", 1'b1, 1'b1, DW'(i * 7 + 3));
        for (int i = 0; i < 3; i++) cyc("to7", 1'b0, 1'b1, '0);
        check("pre_rst_cnt", data_count_w, 7);

        // Mid-operation reset; requests during reset are ignored
        do_reset(1, 1'b1, 1'b1);
        check("post_rst_data", read_data, 12'h000);
        cyc("post_rst_wr", 1'b1, 1'b0, 12'h5A5);
        check("post_rst_new", read_data, 12'h5A5);
        cyc("post_rst_rd", 1'b0, 1'b1, '0);
        check("post_rst_empty", rempty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
